// File: rtl/temporizador_parametrizado.sv
// temporizador_parametrizado: HH:MM:SS countdown timer / stopwatch with
// three-button time setting and six active-high 7-segment digit outputs.
// Build option: define TIMER_ALARM_EN to get an alarm pulse lasting
// ALARM_TICKS seconds after DONE entry; otherwise alarm is tied low.
module temporizador_parametrizado #(
  parameter int TICK_DIV    = 50000000,
  parameter int HOUR_MAX    = 23,
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_run,
  input  logic       count_up,
  output logic [6:0] seg_hh_d,
  output logic [6:0] seg_hh_u,
  output logic [6:0] seg_mm_d,
  output logic [6:0] seg_mm_u,
  output logic [6:0] seg_ss_d,
  output logic [6:0] seg_ss_u,
  output logic [2:0] set_leds,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int              PW     = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   TC     = PW'(TICK_DIV - 1);
  localparam logic [7:0]      HMAX   = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
  localparam logic [23:0]     TM_MAX = {HMAX, 16'h5959};

  typedef enum logic [2:0] {IDLE, SET_S, SET_M, SET_H, RUN, DONE} state_t;

  state_t          state;
  state_t          state_n;
  logic [23:0]     tm;        // {hh_d, hh_u, mm_d, mm_u, ss_d, ss_u}
  logic [23:0]     tm_up;
  logic [23:0]     tm_dn;
  logic            up_mode;
  logic [PW-1:0]   presc;
  logic            mode_prev;
  logic            inc_prev;
  logic            run_prev;
  logic            mode_e;
  logic            inc_e;
  logic            run_e;
  logic            count_st;
  logic            tick;
  logic            at_max;

  // Two-digit BCD increment, wrapping from max back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)            return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-digit BCD decrement, wrapping from 00 up to max.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)          return max;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Segment pattern {g,f,e,d,c,b,a}; anything that is not a BCD digit is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  assign mode_e = btn_mode & ~mode_prev;
  assign inc_e  = btn_inc  & ~inc_prev;
  assign run_e  = btn_run  & ~run_prev;
  assign tick   = count_st && (presc == TC);
  assign at_max = (tm == TM_MAX);

  // Button history; loading current levels during reset suppresses edges from buttons held across release.
  always_ff @(posedge clk) begin
    mode_prev <= btn_mode;
    inc_prev  <= btn_inc;
    run_prev  <= btn_run;
  end

  // Candidate next times for one second up (carry) and one second down (borrow).
  always_comb begin
    tm_up       = tm;
    tm_up[7:0]  = bcd_inc(tm[7:0], 8'h59);
    if (tm[7:0] == 8'h59) begin
      tm_up[15:8] = bcd_inc(tm[15:8], 8'h59);
      if (tm[15:8] == 8'h59) tm_up[23:16] = bcd_inc(tm[23:16], HMAX);
    end
    tm_dn       = tm;
    tm_dn[7:0]  = bcd_dec(tm[7:0], 8'h59);
    if (tm[7:0] == 8'h00) begin
      tm_dn[15:8] = bcd_dec(tm[15:8], 8'h59);
      if (tm[15:8] == 8'h00) tm_dn[23:16] = bcd_dec(tm[23:16], 8'h99);
    end
  end

  // Next state: run edge outranks mode/inc; a zero countdown cannot be started.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, SET_S, SET_M, SET_H: begin
        if (run_e) begin
          if (count_up || (tm != 24'h0)) state_n = RUN;
        end else if (mode_e) begin
          case (state)
            IDLE:    state_n = SET_S;
            SET_S:   state_n = SET_M;
            SET_M:   state_n = SET_H;
            default: state_n = IDLE;
          endcase
        end
      end
      RUN: begin
        if (run_e) begin
          state_n = IDLE;
        end else if (tick) begin
          if (up_mode) begin
            if (at_max || (tm_up == TM_MAX)) state_n = DONE;
          end else if (tm_dn == 24'h0) begin
            state_n = DONE;
          end
        end
      end
      DONE:    if (mode_e || inc_e || run_e) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, registered status outputs, prescaler and time digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tm       <= '0;
      presc    <= '0;
      up_mode  <= 1'b0;
      set_leds <= 3'b000;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == RUN);
      done    <= (state_n == DONE);
      case (state_n)
        SET_S:   set_leds <= 3'b001;
        SET_M:   set_leds <= 3'b010;
        SET_H:   set_leds <= 3'b100;
        default: set_leds <= 3'b000;
      endcase
      if ((state_n != state) || tick) presc <= '0;
      else if (count_st)              presc <= presc + PW'(1);
      if ((state_n == RUN) && (state != RUN)) up_mode <= count_up;
      case (state)
        SET_S: if (!run_e && !mode_e && inc_e) tm[7:0]   <= bcd_inc(tm[7:0], 8'h59);
        SET_M: if (!run_e && !mode_e && inc_e) tm[15:8]  <= bcd_inc(tm[15:8], 8'h59);
        SET_H: if (!run_e && !mode_e && inc_e) tm[23:16] <= bcd_inc(tm[23:16], HMAX);
        RUN:   if (!run_e && tick && !(up_mode && at_max)) tm <= up_mode ? tm_up : tm_dn;
        default: ;
      endcase
    end
  end

`ifdef TIMER_ALARM_EN
  logic [7:0] alarm_cnt;

  assign count_st = (state == RUN) || (state == DONE);

  // Alarm rises on DONE entry and drops after ALARM_TICKS seconds or when DONE is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else if ((state_n == DONE) && (state != DONE)) begin
      alarm     <= 1'b1;
      alarm_cnt <= '0;
    end else if (state_n != DONE) begin
      alarm     <= 1'b0;
    end else if (tick && alarm) begin
      alarm_cnt <= alarm_cnt + 8'd1;
      if (alarm_cnt == 8'(ALARM_TICKS - 1)) alarm <= 1'b0;
    end
  end
`else
  assign count_st = (state == RUN);
  assign alarm    = 1'b0;
`endif

  assign seg_hh_d = seg7(tm[23:20]);
  assign seg_hh_u = seg7(tm[19:16]);
  assign seg_mm_d = seg7(tm[15:12]);
  assign seg_mm_u = seg7(tm[11:8]);
  assign seg_ss_d = seg7(tm[7:4]);
  assign seg_ss_u = seg7(tm[3:0]);

endmodule

// File: tb/tb_temporizador_parametrizado.sv
// Bench for temporizador_parametrizado: two instances share all inputs,
// one with HOUR_MAX=23 and one with HOUR_MAX=1, both with TICK_DIV=4.
module tb_temporizador_parametrizado;

  localparam int TD   = 4;
  localparam int MODE = 0;
  localparam int INC  = 1;
  localparam int RUN  = 2;
`ifdef TIMER_ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, btn_mode, btn_inc, btn_run, count_up;
  logic [6:0] a_hd, a_hu, a_md, a_mu, a_sd, a_su;
  logic [6:0] b_hd, b_hu, b_md, b_mu, b_sd, b_su;
  logic [2:0] a_leds, b_leds;
  logic a_run, a_done, a_alarm, b_run, b_done, b_alarm;

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] sb[$];
  logic [47:0] got, want;

  always #5 clk = ~clk;

  temporizador_parametrizado #(.TICK_DIV(TD), .HOUR_MAX(23), .ALARM_TICKS(3)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_run(btn_run),
    .count_up(count_up), .seg_hh_d(a_hd), .seg_hh_u(a_hu), .seg_mm_d(a_md), .seg_mm_u(a_mu),
    .seg_ss_d(a_sd), .seg_ss_u(a_su), .set_leds(a_leds), .running(a_run), .done(a_done),
    .alarm(a_alarm));

  temporizador_parametrizado #(.TICK_DIV(TD), .HOUR_MAX(1), .ALARM_TICKS(3)) dut_h1 (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_run(btn_run),
    .count_up(count_up), .seg_hh_d(b_hd), .seg_hh_u(b_hu), .seg_mm_d(b_md), .seg_mm_u(b_mu),
    .seg_ss_d(b_sd), .seg_ss_u(b_su), .set_leds(b_leds), .running(b_run), .done(b_done),
    .alarm(b_alarm));

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [47:0] expv(input int hh, input int mm, input int ss,
                                       input bit r, input bit dn, input bit al,
                                       input logic [2:0] l);
    return {enc(hh / 10), enc(hh % 10), enc(mm / 10), enc(mm % 10),
            enc(ss / 10), enc(ss % 10), r, dn, al, l};
  endfunction

  function automatic logic [47:0] obs_a();
    return {a_hd, a_hu, a_md, a_mu, a_sd, a_su, a_run, a_done, a_alarm, a_leds};
  endfunction

  function automatic logic [47:0] obs_b();
    return {b_hd, b_hu, b_md, b_mu, b_sd, b_su, b_run, b_done, b_alarm, b_leds};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which);
    case (which)
      MODE:    btn_mode = 1'b1;
      INC:     btn_inc  = 1'b1;
      default: btn_run  = 1'b1;
    endcase
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_run = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_n(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_run = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_run = 1'b1; count_up = 1'b1;
    cyc(3);
    sb.push_back(expv(0, 0, 0, 0, 0, 0, 3'b000));
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL reset_state got=%h want=%h", got, want); end
    reset = 1'b0;
    sb.push_back(expv(0, 0, 0, 0, 0, 0, 3'b000));
    cyc(4);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL held_run_no_edge got=%h want=%h", got, want); end
    btn_run = 1'b0;
    cyc(1);
    sb.push_back(expv(0, 0, 0, 1, 0, 0, 3'b000));
    press(RUN);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL repress_runs got=%h want=%h", got, want); end
    press(RUN);
    count_up = 1'b0;
  endtask

  task automatic test_countdown();
    do_reset();
    count_up = 1'b0;
    sb.push_back(expv(0, 0, 0, 0, 0, 0, 3'b000));
    press(RUN);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL cd_zero_block got=%h want=%h", got, want); end
    press(MODE); press_n(INC, 2); press(MODE); press(INC); press(MODE); press(MODE);
    sb.push_back(expv(0, 1, 2, 0, 0, 0, 3'b000));
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL set_000102 got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 1, 1, 0, 0, 3'b000));
    press(RUN);
    cyc(246);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL cd_before_done got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 0, 0, 1, ALM, 3'b000));
    cyc(1);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL cd_done got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 0, 0, 1, ALM, 3'b000));
    cyc(11);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL alarm_last_cycle got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 0, 0, 1, 0, 3'b000));
    cyc(1);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL alarm_off got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 0, 0, 0, 0, 3'b000));
    press(MODE);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL done_exit got=%h want=%h", got, want); end
  endtask

  task automatic test_sec_wrap();
    do_reset();
    press(MODE); press(MODE); press_n(INC, 3); press(MODE); press_n(INC, 2);
    press(MODE); press(MODE);
    sb.push_back(expv(2, 3, 0, 0, 0, 0, 3'b001));
    sb.push_back(expv(0, 3, 0, 0, 0, 0, 3'b001));
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL set_sec_leds got=%h want=%h", got, want); end
    got = obs_b(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL hour_wrap_h1 got=%h want=%h", got, want); end
    sb.push_back(expv(2, 3, 59, 0, 0, 0, 3'b001));
    press_n(INC, 59);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL sec_59 got=%h want=%h", got, want); end
    sb.push_back(expv(2, 3, 0, 0, 0, 0, 3'b001));
    press(INC);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL sec_wrap got=%h want=%h", got, want); end
  endtask

  task automatic test_stopwatch_max();
    do_reset();
    count_up = 1'b1;
    press(MODE); press_n(INC, 58); press(MODE); press_n(INC, 59); press(MODE); press(INC);
    press(MODE);
    sb.push_back(expv(1, 59, 59, 0, 1, ALM, 3'b000));
    sb.push_back(expv(2, 0, 0, 1, 0, 0, 3'b000));
    press(RUN);
    cyc(7);
    got = obs_b(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL sw_max_done got=%h want=%h", got, want); end
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL sw_carry_hour got=%h want=%h", got, want); end
    do_reset();
    press(MODE); press_n(INC, 59); press(MODE); press_n(INC, 59); press(MODE); press(MODE);
    sb.push_back(expv(1, 0, 0, 1, 0, 0, 3'b000));
    press(RUN);
    cyc(3);
    got = obs_b(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL sw_carry_h1 got=%h want=%h", got, want); end
    count_up = 1'b0;
  endtask

  task automatic test_run_priority();
    do_reset();
    count_up = 1'b0;
    press(MODE); press_n(INC, 5); press(MODE); press(MODE); press(MODE);
    sb.push_back(expv(0, 0, 5, 1, 0, 0, 3'b000));
    btn_run = 1'b1; btn_mode = 1'b1;
    cyc(1);
    btn_run = 1'b0; btn_mode = 1'b0;
    cyc(1);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL run_over_mode got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 4, 1, 0, 0, 3'b000));
    cyc(3);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL first_tick got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 4, 0, 0, 0, 3'b000));
    press(RUN);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL pause got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 4, 0, 0, 0, 3'b000));
    cyc(8);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL pause_hold got=%h want=%h", got, want); end
    sb.push_back(expv(0, 0, 3, 1, 0, 0, 3'b000));
    press(RUN);
    cyc(3);
    got = obs_a(); want = sb.pop_front(); n_checks++;
    if (got !== want) begin n_errors++; $display("FAIL resume got=%h want=%h", got, want); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_run = 1'b0; count_up = 1'b0;
    @(negedge clk);
    test_reset();
    test_countdown();
    test_sec_wrap();
    test_stopwatch_max();
    test_run_priority();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
